// File: rtl/tick_sel_divider.sv
// rtl/tick_sel_divider.sv - selectable-rate tick divider with filtered switch select
// Rate changes take effect only at a terminal count, so every period is whole.
module tick_sel_divider #(
    parameter int N_SEL = 4,
    parameter int SEL_W = 2,
    // 29 bits so the 6 s period (300M cycles at 50 MHz) fits without truncation
    parameter int CNT_W = 29,
    parameter logic [N_SEL*CNT_W-1:0] DIVS = {29'd300000000, 29'd100000000,
                                              29'd50000000,  29'd25000000},
    parameter int STABLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel_in,
    output logic             tick,
    output logic             sq_out,
    output logic [SEL_W-1:0] active_sel,
    output logic             switch_pending
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYC);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);

    logic [SEL_W-1:0] sync_a;
    logic [SEL_W-1:0] sel_sync;
    logic [SEL_W-1:0] sel_prev;
    logic [STAB_W-1:0] stab;
    logic [SEL_W-1:0] pending_sel;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] div_tab [N_SEL];
    logic [CNT_W-1:0] term_val;
    logic             sel_valid;
    logic             stab_eq;
    logic             accept;
    logic             terminal;
    logic [SEL_W-1:0] pending_nx;
    logic [SEL_W-1:0] active_nx;

    for (genvar i = 0; i < N_SEL; i++) begin : g_div
        assign div_tab[i] = DIVS[i*CNT_W +: CNT_W];
    end

    // Codes beyond the last rate only exist when N_SEL is not a power of two
    if ((1 << SEL_W) == N_SEL) begin : g_full
        assign sel_valid = 1'b1;
    end else begin : g_part
        assign sel_valid = (int'(sel_sync) < N_SEL);
    end

    always_comb begin
        term_val   = div_tab[active_sel] - CNT_W'(1);
        stab_eq    = (sel_sync == sel_prev);
        accept     = stab_eq && (stab == STAB_LAST) && sel_valid;
        terminal   = en && (cnt == term_val);
        pending_nx = pending_sel;
        active_nx  = active_sel;
        if (accept) begin
            pending_nx = sel_sync;
        end
        // The boundary applies the pending value held before this edge, so a
        // same-cycle acceptance waits for the following boundary.
        if (terminal) begin
            active_nx = pending_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a         <= '0;
            sel_sync       <= '0;
            sel_prev       <= '0;
            stab           <= '0;
            pending_sel    <= '0;
            active_sel     <= '0;
            switch_pending <= 1'b0;
            cnt            <= '0;
            tick           <= 1'b0;
            sq_out         <= 1'b0;
        end else begin
            sync_a   <= sel_in;
            sel_sync <= sync_a;
            sel_prev <= sel_sync;
            if (!stab_eq) begin
                stab <= '0;
            end else if (stab != STAB_MAX) begin
                stab <= stab + STAB_W'(1);
            end
            pending_sel    <= pending_nx;
            active_sel     <= active_nx;
            switch_pending <= (pending_nx != active_nx);
            tick           <= terminal;
            if (terminal) begin
                cnt    <= '0;
                sq_out <= ~sq_out;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tick_sel_divider.sv
// tb/tb_tick_sel_divider.sv - scoreboard bench for tick_sel_divider
// Expected ticks are queued with hand-computed edge numbers; a monitor pops them.
module tb_tick_sel_divider;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel_in;
    logic       tick;
    logic       sq_out;
    logic [1:0] active_sel;
    logic       switch_pending;

    int errors = 0;
    int checks = 0;
    int pe = 0;

    typedef struct {
        int         pe;
        logic [1:0] act;
        logic       sq;
    } exp_t;
    exp_t q[$];

    tick_sel_divider #(
        .N_SEL(4),
        .SEL_W(2),
        .CNT_W(8),
        .DIVS({8'd4, 8'd6, 8'd8, 8'd12}),
        .STABLE_CYC(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sel_in(sel_in),
        .tick(tick),
        .sq_out(sq_out),
        .active_sel(active_sel),
        .switch_pending(switch_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe <= 0;
        else        pe <= pe + 1;
    end

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at pe=%0d: got %0d expected %0d", name, pe, act, req);
        end
    endtask

    task automatic push(input int p, input int a, input int s);
        exp_t e;
        e.pe  = p;
        e.act = 2'(a);
        e.sq  = s[0];
        q.push_back(e);
    endtask

    task automatic at(input int n);
        @(negedge clk);
        while (pe != n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && tick) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick at pe=%0d: got tick expected none", pe);
            end else begin
                e = q.pop_front();
                cmp("tick_pe", pe, e.pe);
                cmp("tick_active", int'(active_sel), int'(e.act));
                cmp("tick_sq", int'(sq_out), int'(e.sq));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b1;
        en     = 1'b1;
        sel_in = 2'd0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_tick", int'(tick), 0);
        cmp("rst_sq", int'(sq_out), 0);
        cmp("rst_active", int'(active_sel), 0);
        cmp("rst_pending", int'(switch_pending), 0);

        // Rate 0, then a 2-cycle glitch to 3 that must be rejected
        push(12, 0, 1); push(24, 0, 0); push(36, 0, 1);
        push(48, 0, 0); push(60, 0, 1);
        rst_n = 1'b1;
        at(39); sel_in = 2'd3;
        at(41); sel_in = 2'd0;
        at(44); cmp("glitch_pending", int'(switch_pending), 0);

        // Switch 0 -> 2 mid-period, then back to 0 accepted on a boundary edge
        at(64);
        push(72, 2, 0); push(78, 2, 1); push(84, 2, 0); push(90, 2, 1);
        push(96, 2, 0);
        sel_in = 2'd2;
        at(69); cmp("sw2_pending_before", int'(switch_pending), 0);
        at(70); cmp("sw2_pending_set", int'(switch_pending), 1);
        at(71); cmp("sw2_active_held", int'(active_sel), 0);
        at(72); cmp("sw2_pending_clr", int'(switch_pending), 0);
        cmp("sw2_active", int'(active_sel), 2);
        at(90); sel_in = 2'd0;
        at(96); cmp("simul_active", int'(active_sel), 2);
        cmp("simul_pending", int'(switch_pending), 1);

        // Select 1 then 3 inside one period; only 3 is applied
        at(97);
        push(102, 0, 1); push(114, 3, 0); push(118, 3, 1); push(122, 3, 0);
        push(126, 0, 1);
        sel_in = 2'd1;
        at(102); cmp("sw0_pending_clr", int'(switch_pending), 0);
        sel_in = 2'd3;
        at(103); cmp("sel1_pending", int'(switch_pending), 1);
        at(108); cmp("sel3_pending", int'(switch_pending), 1);
        cmp("sel3_active_held", int'(active_sel), 0);
        at(114); cmp("sel3_active", int'(active_sel), 3);
        cmp("sel3_pending_clr", int'(switch_pending), 0);
        at(119); sel_in = 2'd0;

        // Freeze at cnt=7 for 20 cycles; a switch accepted meanwhile waits
        at(133);
        push(158, 2, 0); push(164, 2, 1);
        en = 1'b0;
        at(135); sel_in = 2'd2;
        at(150); cmp("freeze_sq", int'(sq_out), 1);
        cmp("freeze_pending", int'(switch_pending), 1);
        cmp("freeze_active", int'(active_sel), 0);
        at(153); en = 1'b1;

        // Asynchronous reset mid-period at rate 2
        at(166);
        sel_in = 2'd0;
        rst_n  = 1'b0;
        #1;
        cmp("mid_rst_tick", int'(tick), 0);
        cmp("mid_rst_sq", int'(sq_out), 0);
        cmp("mid_rst_active", int'(active_sel), 0);
        cmp("mid_rst_pending", int'(switch_pending), 0);
        push(12, 0, 1); push(24, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        at(1); cmp("post_rst_active", int'(active_sel), 0);
        at(26);
        cmp("ticks_remaining", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
